// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS31 (x^31+x^28+1) BERT sequencer and lane checkers:
// FSM state encoding, tap positions and the generator reset seed.
package prbs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_LOCK  = 3'd2,
    ST_COUNT = 3'd3,
    ST_DONE  = 3'd4
  } bert_state_t;

  localparam int          PRBS_LEN  = 31;
  localparam int          PRBS_TAP  = 27;
  localparam logic [30:0] PRBS_SEED = 31'h55555555;

  // Next bit predicted from a history whose bit 0 is the newest sample.
  function automatic logic prbs31_next(input logic [PRBS_LEN-1:0] hist);
    return hist[PRBS_LEN-1] ^ hist[PRBS_TAP];
  endfunction

endpackage

// File: rtl/prbs31_chk.sv
// Self-synchronising PRBS31 checker: shifts qualified bits into a 31-bit history
// and flags a received bit that disagrees with the polynomial prediction.
module prbs31_chk
  import prbs_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  output logic err
);

  logic [PRBS_LEN-1:0] hist_r;

  // History shift register, advanced only on qualified bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_r <= {PRBS_LEN{1'b0}};
    end else if (en) begin
      hist_r <= {hist_r[PRBS_LEN-2:0], din};
    end else begin
      hist_r <= hist_r;
    end
  end

  assign err = din ^ prbs31_next(hist_r);

endmodule

// File: rtl/prbs31_bert_ctrl.sv
// PRBS31 bit-error-rate test sequencer: sync, lock qualification, bit/error counting.
// Optional first-error capture outputs are built when PRBS_FIRST_ERR_EN is defined.
module prbs31_bert_ctrl
  import prbs_pkg::*;
#(
  parameter int LEN_W    = 40,
  parameter int ERR_W    = 32,
  parameter int LOCK_CNT = 64,
  parameter int LOSS_CNT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] bit_len,
  input  logic             rx_bit,
  input  logic             rx_valid,
  output logic             gen_rst,
  output logic             busy,
  output logic             locked,
  output logic             done,
  output logic             lock_lost,
  output logic [LEN_W-1:0] bit_cnt,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       state
`ifdef PRBS_FIRST_ERR_EN
  ,
  output logic             first_err_vld,
  output logic [LEN_W-1:0] first_err_pos
`endif
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int LOSS_W  = $clog2(LOSS_CNT + 1);

  localparam logic [4:0]         FILL_LAST  = 5'd30;
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_CNT - 1);
  localparam logic [LEN_W-1:0]   LEN_ONE    = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0]   ERR_ONE    = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0]   ERR_MAX    = {ERR_W{1'b1}};

  bert_state_t        state_r;
  logic [LEN_W-1:0]   len_r;
  logic [4:0]         fill_r;
  logic [MATCH_W-1:0] match_r;
  logic [LOSS_W-1:0]  loss_r;
  logic               chk_err_s;
  logic [LEN_W-1:0]   bit_nxt_s;

  prbs31_chk u_chk (
    .clk (clk),
    .rst (rst),
    .en  (rx_valid),
    .din (rx_bit),
    .err (chk_err_s)
  );

  assign bit_nxt_s = bit_cnt + LEN_ONE;
  assign state     = state_r;

  // Sequencer FSM with all status outputs and counters registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      len_r     <= {LEN_W{1'b0}};
      fill_r    <= 5'd0;
      match_r   <= {MATCH_W{1'b0}};
      loss_r    <= {LOSS_W{1'b0}};
      gen_rst   <= 1'b1;
      busy      <= 1'b0;
      locked    <= 1'b0;
      done      <= 1'b0;
      lock_lost <= 1'b0;
      bit_cnt   <= {LEN_W{1'b0}};
      err_cnt   <= {ERR_W{1'b0}};
`ifdef PRBS_FIRST_ERR_EN
      first_err_vld <= 1'b0;
      first_err_pos <= {LEN_W{1'b0}};
`endif
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Counters are left untouched so the aborted run can still be read out
        state_r <= ST_IDLE;
        gen_rst <= 1'b1;
        busy    <= 1'b0;
        locked  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              len_r     <= (bit_len == {LEN_W{1'b0}}) ? LEN_ONE : bit_len;
              bit_cnt   <= {LEN_W{1'b0}};
              err_cnt   <= {ERR_W{1'b0}};
              lock_lost <= 1'b0;
              fill_r    <= 5'd0;
              state_r   <= ST_SYNC;
              gen_rst   <= 1'b0;
              busy      <= 1'b1;
              locked    <= 1'b0;
`ifdef PRBS_FIRST_ERR_EN
              first_err_vld <= 1'b0;
              first_err_pos <= {LEN_W{1'b0}};
`endif
            end
          end
          ST_SYNC: begin
            if (rx_valid) begin
              if (fill_r == FILL_LAST) begin
                state_r <= ST_LOCK;
                match_r <= {MATCH_W{1'b0}};
              end else begin
                fill_r <= fill_r + 5'd1;
              end
            end
          end
          ST_LOCK: begin
            if (rx_valid) begin
              if (chk_err_s) begin
                match_r <= {MATCH_W{1'b0}};
              end else if (match_r == MATCH_LAST) begin
                state_r <= ST_COUNT;
                locked  <= 1'b1;
                loss_r  <= {LOSS_W{1'b0}};
              end else begin
                match_r <= match_r + {{(MATCH_W-1){1'b0}}, 1'b1};
              end
            end
          end
          ST_COUNT: begin
            if (rx_valid) begin
              bit_cnt <= bit_nxt_s;
              if (chk_err_s && (err_cnt != ERR_MAX)) begin
                err_cnt <= err_cnt + ERR_ONE;
              end
`ifdef PRBS_FIRST_ERR_EN
              if (chk_err_s && !first_err_vld) begin
                first_err_vld <= 1'b1;
                first_err_pos <= bit_cnt;
              end
`endif
              // Completion is tested first so it wins over a loss on the same bit
              if (bit_nxt_s == len_r) begin
                state_r <= ST_DONE;
                done    <= 1'b1;
                busy    <= 1'b0;
                locked  <= 1'b0;
              end else if (chk_err_s && (loss_r == LOSS_LAST)) begin
                state_r   <= ST_SYNC;
                fill_r    <= 5'd0;
                lock_lost <= 1'b1;
                locked    <= 1'b0;
              end else if (chk_err_s) begin
                loss_r <= loss_r + {{(LOSS_W-1){1'b0}}, 1'b1};
              end else begin
                loss_r <= {LOSS_W{1'b0}};
              end
            end
          end
          default: begin
            state_r <= ST_IDLE;
            gen_rst <= 1'b1;
            busy    <= 1'b0;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/prbs31_bert_ctrl.md
Name: prbs31_bert_ctrl

Overview:
- PRBS31 bit-error-rate test sequencer for SerDes loopback bring-up.
- Takes the serial PRBS31 stream (polynomial x^31+x^28+1) back from the link and drives the reset of the local PRBS31 generator.
- Self-synchronises a checker to the received stream, qualifies lock, then counts bits and errors over a programmed length.
- Sits between the register/control interface and the TX generator / RX deserialiser bit output.

Parameters:
- LEN_W, 40, width of bit-length and bit counter.
- ERR_W, 32, width of error counter (saturating).
- LOCK_CNT, 64, consecutive error-free bits required to declare lock.
- LOSS_CNT, 8, consecutive errored bits in COUNT that declare loss of lock.

Ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; starts a test when idle.
- abort  in  1  one-cycle pulse; returns to IDLE from any state.
- bit_len  in  LEN_W  number of bits to check in COUNT; sampled on start; 0 is treated as 1.
- rx_bit  in  1  received serial bit.
- rx_valid  in  1  rx_bit qualifier; only qualified bits advance any state.
- gen_rst  out  1  active-high reset to the TX PRBS31 generator.
- busy  out  1  high in SYNC, LOCK, COUNT.
- locked  out  1  high in COUNT.
- done  out  1  one-cycle pulse on COUNT->DONE.
- lock_lost  out  1  sticky; set on COUNT->SYNC; cleared by start.
- bit_cnt  out  LEN_W  bits checked in the current COUNT phase.
- err_cnt  out  ERR_W  errored bits in the current COUNT phase; saturates at all-ones.
- state  out  3  encoded FSM state, for debug.

Behaviour:
- Reset values: state=IDLE, gen_rst=1, all other outputs 0, history register 0.
- Checker:
  - 31-bit history register, hist[0] = newest qualified bit.
  - Expected bit = hist[30]^hist[27].
  - err = rx_bit ^ expected.
  - On each rx_valid, shift rx_bit in (self-synchronising; no seed needed).
- States and encoding: IDLE=0, SYNC=1, LOCK=2, COUNT=3, DONE=4.
- IDLE: gen_rst=1.
  - On start: latch bit_len, clear bit_cnt, err_cnt and lock_lost, fill counter = 0 -> SYNC.
  - gen_rst deasserts the same cycle state becomes SYNC, i.e. registered one cycle after start.
- SYNC: count 31 qualified bits into history; on the 31st -> LOCK, match counter = 0. No error evaluation.
- LOCK:
  - Each qualified bit: err=0 increments the match counter; err=1 clears it.
  - When the counter reaches LOCK_CNT -> COUNT. The bit that completes the count is not counted in bit_cnt.
- COUNT:
  - Each qualified bit increments bit_cnt; err=1 increments err_cnt (saturating).
  - Consecutive-error counter: clears on err=0.
  - Reaching LOSS_CNT consecutive errors -> SYNC, set lock_lost, keep bit_cnt/err_cnt frozen.
  - If bit_cnt reaches the latched bit_len on a bit -> DONE, with done pulsed that cycle. Completion has priority over loss on the same bit.
- DONE: counters hold, gen_rst=0. start restarts as from IDLE; abort -> IDLE.
- abort: highest priority in every state; next cycle state=IDLE, gen_rst=1, counters hold their values for readout.
- start while busy: ignored.
- Simultaneous start+abort: abort wins.
- rx_valid low: all state, counters and history hold.
- Reset mid-test: immediate return to reset values.

Optional Feature:
- Macro PRBS_FIRST_ERR_EN.
- When defined, adds outputs first_err_vld (1) and first_err_pos (LEN_W).
  - On the first errored bit in COUNT, capture the pre-increment bit_cnt and set first_err_vld.
  - Both are cleared by start.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package prbs_pkg:
  - State encoding constants.
  - PRBS31 tap constants (length 31, tap 27).
  - Generator reset seed 31'h55555555.
- Sub-module prbs31_chk: history register plus err output, enabled by rx_valid. It is reusable by other lane checkers.

Test Plan:
- Clean loop: feed the generator output to rx_bit with rx_valid=1 and bit_len=1000 -> lock after 31+64 bits; done pulses after 1000 COUNT bits; err_cnt=0; bit_cnt=1000.
- Single error: invert one rx bit at COUNT index 500 -> err_cnt=3 (the flipped bit plus its two tap echoes at +28 and +31); no lock loss; with PRBS_FIRST_ERR_EN, first_err_pos=500.
- Loss: drive rx_bit constant 1 in COUNT -> after 8 consecutive errors state=SYNC and lock_lost=1; resume the PRBS -> relock and complete.
- Gating: rx_valid toggled 50% -> identical err_cnt/bit_cnt to the clean case; completion takes twice as many cycles.
- Abort at bit 200 of COUNT -> next cycle state=IDLE, gen_rst=1, bit_cnt=200 held; a following start clears the counters.
- Saturation: ERR_W=4 with random data and LOSS_CNT large -> err_cnt stops at 15.
